shift_load_controller: RTL and testbench
========================================

Name: shift_load_controller

Overview:
- Sequencer that loads a parallel word into the team's serial-in 4-bit shift register (single serial input, synchronous clear).
- On a start request it optionally clears the register, then drives WIDTH serial bits so that register stage Q[k] ends holding data_in[k].
- Keeps a shadow copy of the register contents for checking and readback.
- Sits between control logic and the register instance, and owns the register's in/reset pins.

Parameters:
- WIDTH, 4, number of register stages / bits per load (min 2).
- CLEAR_FIRST, 1, 1 = insert one clear cycle before shifting; 0 = shift immediately.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  load request; sampled only in IDLE.
- abort  input  1  cancel an in-progress load; sampled in CLEAR and SHIFT.
- data_in  input  WIDTH  word to load; captured on the edge that accepts start.
- busy  output  1  high in CLEAR, SHIFT and ABORT.
- done  output  1  one-cycle pulse in DONE state.
- sr_in  output  1  serial bit to the register's in pin.
- sr_shift  output  1  high while sr_in carries a valid bit (register clock-enable qualifier).
- sr_reset  output  1  clear to the register's reset pin.
- shadow  output  WIDTH  model of the register contents.

Behaviour:
- Register model: on an edge with sr_reset=1, Q<=0. On an edge with sr_shift=1, Q[0]<=sr_in and Q[i]<=Q[i-1]. sr_reset has priority.
- Output timing: all outputs are registered (Moore); there are no combinational paths from inputs to outputs.
- Reset: state=IDLE, bit counter=0, captured word=0, shadow=0; busy, done, sr_in, sr_shift and sr_reset all 0.
  - Reset wins over start and abort in the same cycle.
  - Reset mid-load drops the load without a done pulse. The external register is not cleared by the controller on reset.
- States: IDLE, CLEAR, SHIFT, DONE, ABORT.
- IDLE:
  - start=1 -> capture data_in, counter<=0.
  - Next state is CLEAR if CLEAR_FIRST=1, else SHIFT.
  - start=0 -> stay in IDLE.
- CLEAR: sr_reset=1, busy=1, lasts one cycle -> SHIFT.
- SHIFT:
  - sr_shift=1, busy=1, sr_in=captured[WIDTH-1-counter] (MSB first).
  - counter increments each cycle.
  - At counter=WIDTH-1 -> DONE.
  - Lasts exactly WIDTH cycles.
- DONE: done=1, busy=0, shadow equals the captured word; lasts one cycle -> IDLE.
- ABORT:
  - Entered from CLEAR or SHIFT when abort=1; abort takes priority over counter completion.
  - Outputs: sr_reset=1, busy=1, sr_shift=0.
  - Lasts one cycle -> IDLE; no done pulse.
- shadow update: follows the register model using the controller's own sr_reset, sr_shift and sr_in outputs. It therefore matches the external register after every edge.
- Latency, start edge to done high:
  - WIDTH+2 edges with CLEAR_FIRST=1.
  - WIDTH+1 edges with CLEAR_FIRST=0.
- Ignored inputs:
  - start outside IDLE is ignored and not queued; this includes start in DONE, so back-to-back loads are spaced by one IDLE cycle.
  - abort in IDLE and in DONE is ignored.
  - data_in is don't-care except on the accepting edge.
- CLEAR_FIRST=0: old register contents are shifted out. After a full load the shadow still equals the new word, because all WIDTH stages are overwritten.

Test Plan:
- Reset, then start with data_in=4'b1011, WIDTH=4, CLEAR_FIRST=1 -> sr_reset high for 1 cycle; sr_in sequence 1,0,1,1 with sr_shift high for 4 cycles; done pulses 6 edges after start; shadow=4'b1011 and busy=0 during done.
- Back-to-back: 4'b0110 then start held high through DONE -> second load begins only after one IDLE cycle; final shadow=4'b0110; exactly two done pulses.
- Abort in the 2nd SHIFT cycle of a 4'b1111 load -> next cycle ABORT with sr_reset=1; then IDLE with shadow=4'b0000; no done pulse.
- Reset asserted mid-SHIFT of 4'b1001 together with start=1 -> next cycle all outputs 0 and state IDLE; no load is accepted that cycle.
- CLEAR_FIRST=0 build: preload 4'b1111, then load 4'b0100 -> no sr_reset; done 5 edges after start; shadow=4'b0100.
- start pulsed while busy, with data_in changing during the load -> ignored; the original captured word is delivered unchanged.

Source files
------------

// File: rtl/shift_load_controller.sv
// Sequencer that loads a parallel word, MSB first, into a serial-in shift register
// and keeps a shadow copy of the register contents.
//
// state   | meaning
// IDLE    | waiting for start; captures data_in on the accepting edge
// CLEAR   | one cycle with sr_reset high before shifting
// SHIFT   | WIDTH cycles driving sr_in with sr_shift high, MSB first
// DONE    | one-cycle done pulse; shadow holds the loaded word
// ABORT   | one cycle with sr_reset high after a cancelled load
module shift_load_controller #(
    parameter int WIDTH       = 4,
    parameter bit CLEAR_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic             done,
    output logic             sr_in,
    output logic             sr_shift,
    output logic             sr_reset,
    output logic [WIDTH-1:0] shadow
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_SHIFT,
        S_DONE,
        S_ABORT
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] word;

    // word is the captured load, consumed MSB-first so sr_in is always word[WIDTH-1]
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            count    <= '0;
            word     <= '0;
            shadow   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sr_in    <= 1'b0;
            sr_shift <= 1'b0;
            sr_reset <= 1'b0;
        end else begin
            if (sr_reset) begin
                shadow <= '0;
            end else if (sr_shift) begin
                shadow <= {shadow[WIDTH-2:0], sr_in};
            end

            busy     <= 1'b0;
            done     <= 1'b0;
            sr_in    <= 1'b0;
            sr_shift <= 1'b0;
            sr_reset <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (start) begin
                        count <= '0;
                        busy  <= 1'b1;
                        if (CLEAR_FIRST) begin
                            state    <= S_CLEAR;
                            word     <= data_in;
                            sr_reset <= 1'b1;
                        end else begin
                            state    <= S_SHIFT;
                            word     <= {data_in[WIDTH-2:0], 1'b0};
                            sr_in    <= data_in[WIDTH-1];
                            sr_shift <= 1'b1;
                        end
                    end
                end
                S_CLEAR: begin
                    busy <= 1'b1;
                    if (abort) begin
                        state    <= S_ABORT;
                        sr_reset <= 1'b1;
                    end else begin
                        state    <= S_SHIFT;
                        sr_in    <= word[WIDTH-1];
                        sr_shift <= 1'b1;
                        word     <= {word[WIDTH-2:0], 1'b0};
                    end
                end
                S_SHIFT: begin
                    if (abort) begin
                        state    <= S_ABORT;
                        busy     <= 1'b1;
                        sr_reset <= 1'b1;
                    end else if (count == LAST) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else begin
                        count    <= count + 1'b1;
                        busy     <= 1'b1;
                        sr_in    <= word[WIDTH-1];
                        sr_shift <= 1'b1;
                        word     <= {word[WIDTH-2:0], 1'b0};
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                S_ABORT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_load_controller.sv
// Bench for shift_load_controller: both CLEAR_FIRST builds driven with shared stimulus
// and compared every cycle against a schedule-based reference model.
module tb_shift_load_controller;
    localparam int W = 4;

    logic         clock = 1'b0;
    logic         reset, start, abort;
    logic [W-1:0] data_in;

    logic         busy1, done1, sin1, shf1, srr1;
    logic [W-1:0] sh1;
    logic         busy0, done0, sin0, shf0, srr0;
    logic [W-1:0] sh0;

    shift_load_controller #(.WIDTH(W), .CLEAR_FIRST(1'b1)) dut1 (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .data_in(data_in),
        .busy(busy1), .done(done1), .sr_in(sin1), .sr_shift(shf1), .sr_reset(srr1),
        .shadow(sh1)
    );

    shift_load_controller #(.WIDTH(W), .CLEAR_FIRST(1'b0)) dut0 (
        .clock(clock), .reset(reset), .start(start), .abort(abort), .data_in(data_in),
        .busy(busy0), .done(done0), .sr_in(sin0), .sr_shift(shf0), .sr_reset(srr0),
        .shadow(sh0)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: a load is a fixed schedule of positions (optional clear, W shifts, done)
    typedef enum int {K_IDLE, K_CLEAR, K_SHIFT, K_DONE, K_ABORT} kind_t;

    logic         m_act [2];
    logic         m_abt [2];
    int           m_pos [2];
    logic [W-1:0] m_word[2];
    logic [W-1:0] m_sh  [2];

    function automatic kind_t cur_kind(int m);
        int k;
        if (m_abt[m]) return K_ABORT;
        if (!m_act[m]) return K_IDLE;
        k = m_pos[m] - ((m == 1) ? 1 : 0);
        if (k < 0) return K_CLEAR;
        if (k < W) return K_SHIFT;
        return K_DONE;
    endfunction

    function automatic logic cur_bit(int m);
        int k = m_pos[m] - ((m == 1) ? 1 : 0);
        logic [W-1:0] w = m_word[m];
        return w[W-1-k];
    endfunction

    function automatic logic [8:0] exp_out(int m);
        kind_t k = cur_kind(m);
        logic b  = (k == K_CLEAR) || (k == K_SHIFT) || (k == K_ABORT);
        logic d  = (k == K_DONE);
        logic sh = (k == K_SHIFT);
        logic si = sh ? cur_bit(m) : 1'b0;
        logic sr = (k == K_CLEAR) || (k == K_ABORT);
        return {b, d, si, sh, sr, m_sh[m]};
    endfunction

    task automatic model_step(input int m);
        kind_t k = cur_kind(m);
        int cf = (m == 1) ? 1 : 0;
        if (reset) begin
            m_act[m] = 1'b0;
            m_abt[m] = 1'b0;
            m_sh[m]  = '0;
            return;
        end
        if (k == K_CLEAR || k == K_ABORT) m_sh[m] = '0;
        else if (k == K_SHIFT) m_sh[m] = {m_sh[m][W-2:0], cur_bit(m)};
        if ((k == K_CLEAR || k == K_SHIFT) && abort) begin
            m_act[m] = 1'b0;
            m_abt[m] = 1'b1;
        end else if (k == K_IDLE && start) begin
            m_act[m]  = 1'b1;
            m_pos[m]  = 0;
            m_word[m] = data_in;
        end else if (k == K_ABORT) begin
            m_abt[m] = 1'b0;
        end else if (m_act[m]) begin
            m_pos[m] = m_pos[m] + 1;
            if (m_pos[m] > W + cf) m_act[m] = 1'b0;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step(0);
        model_step(1);
        @(negedge clock);
        chk("model_cf1", {23'd0, busy1, done1, sin1, shf1, srr1, sh1}, {23'd0, exp_out(1)});
        chk("model_cf0", {23'd0, busy0, done0, sin0, shf0, srr0, sh0}, {23'd0, exp_out(0)});
    endtask

    typedef struct {
        logic         rst, st, ab;
        logic [W-1:0] d;
        logic [8:0]   exp;
    } vec_t;

    vec_t vt[8];
    int   dones, done_edge;
    logic saw_rst;
    logic [W-1:0] sh_at_done;

    initial begin
        // expected CLEAR_FIRST=1 outputs {busy,done,sr_in,sr_shift,sr_reset,shadow}
        vt[0] = '{1'b1, 1'b0, 1'b0, 4'b0000, 9'b0_0_0_0_0_0000};
        vt[1] = '{1'b0, 1'b1, 1'b0, 4'b1011, 9'b1_0_0_0_1_0000};
        vt[2] = '{1'b0, 1'b0, 1'b0, 4'b0000, 9'b1_0_1_1_0_0000};
        vt[3] = '{1'b0, 1'b0, 1'b0, 4'b0000, 9'b1_0_0_1_0_0001};
        vt[4] = '{1'b0, 1'b0, 1'b0, 4'b0000, 9'b1_0_1_1_0_0010};
        vt[5] = '{1'b0, 1'b0, 1'b0, 4'b0000, 9'b1_0_1_1_0_0101};
        vt[6] = '{1'b0, 1'b0, 1'b0, 4'b0000, 9'b0_1_0_0_0_1011};
        vt[7] = '{1'b0, 1'b0, 1'b0, 4'b0000, 9'b0_0_0_0_0_1011};

        for (int m = 0; m < 2; m++) begin
            m_act[m] = 1'b0; m_abt[m] = 1'b0; m_pos[m] = 0; m_word[m] = '0; m_sh[m] = '0;
        end
        reset = 1'b1; start = 1'b0; abort = 1'b0; data_in = '0;

        for (int i = 0; i < 8; i++) begin
            reset = vt[i].rst; start = vt[i].st; abort = vt[i].ab; data_in = vt[i].d;
            cycle();
            chk($sformatf("vec%0d", i), {23'd0, busy1, done1, sin1, shf1, srr1, sh1},
                {23'd0, vt[i].exp});
        end

        // back-to-back with start held through DONE
        start = 1'b1; data_in = 4'b0110; dones = 0;
        for (int e = 1; e <= 7; e++) begin
            cycle();
            if (done1) dones++;
        end
        chk("b2b_gap_idle", {30'd0, busy1, done1}, 32'd0);
        cycle();
        chk("b2b_restart", {30'd0, busy1, srr1}, 32'd3);
        start = 1'b0;
        repeat (6) begin
            cycle();
            if (done1) dones++;
        end
        chk("b2b_done_count", dones, 2);
        chk("b2b_shadow", {28'd0, sh1}, 32'b0110);

        // abort in the second SHIFT cycle
        repeat (2) cycle();
        start = 1'b1; data_in = 4'b1111; dones = 0;
        cycle();
        start = 1'b0;
        repeat (2) begin
            cycle();
            if (done1) dones++;
        end
        abort = 1'b1;
        cycle();
        chk("abort_state", {23'd0, busy1, done1, sin1, shf1, srr1, sh1}, {23'd0, 9'b1_0_0_0_1_0011});
        abort = 1'b0;
        cycle();
        chk("abort_idle", {23'd0, busy1, done1, sin1, shf1, srr1, sh1}, 32'd0);
        repeat (3) begin
            cycle();
            if (done1) dones++;
        end
        chk("abort_no_done", dones, 0);

        // reset mid-SHIFT together with start
        start = 1'b1; data_in = 4'b1001;
        cycle();
        start = 1'b0;
        repeat (2) cycle();
        reset = 1'b1; start = 1'b1;
        cycle();
        chk("reset_mid_load", {23'd0, busy1, done1, sin1, shf1, srr1, sh1}, 32'd0);
        reset = 1'b0; start = 1'b0;
        cycle();
        chk("reset_no_accept", {23'd0, busy1, done1, sin1, shf1, srr1, sh1}, 32'd0);

        // CLEAR_FIRST=0: preload 1111 then load 0100
        start = 1'b1; data_in = 4'b1111;
        cycle();
        start = 1'b0;
        repeat (7) cycle();
        chk("cf0_preload", {28'd0, sh0}, 32'b1111);
        start = 1'b1; data_in = 4'b0100; saw_rst = 1'b0; done_edge = 0; sh_at_done = '0;
        for (int e = 1; e <= 6; e++) begin
            cycle();
            start = 1'b0;
            if (srr0) saw_rst = 1'b1;
            if (done0) begin
                done_edge  = e;
                sh_at_done = sh0;
            end
        end
        chk("cf0_no_clear", {31'd0, saw_rst}, 32'd0);
        chk("cf0_latency", done_edge, 5);
        chk("cf0_shadow", {28'd0, sh_at_done}, 32'b0100);
        repeat (2) cycle();

        // start pulses and data changes while busy are ignored
        start = 1'b1; data_in = 4'b1010;
        cycle();
        for (int e = 2; e <= 6; e++) begin
            start   = (e == 2) || (e == 4);
            data_in = W'($urandom);
            cycle();
            if (e == 5) chk("busy_ign_cf0", {27'd0, done0, sh0}, {27'd0, 1'b1, 4'b1010});
            if (e == 6) chk("busy_ign_cf1", {27'd0, done1, sh1}, {27'd0, 1'b1, 4'b1010});
        end
        start = 1'b0;
        cycle();

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            reset   = ($urandom_range(0, 49) == 0);
            start   = ($urandom_range(0, 2) == 0);
            abort   = ($urandom_range(0, 11) == 0);
            data_in = W'($urandom);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
